// File: rtl/sync_bank.sv
// sync_bank: destination-domain synchroniser bank. It synchronises CHANNELS
// single-bit inputs, and each channel has its own output mode: level, rise,
// fall or any-edge. The block also terminates the receive half of a
// toggle-handshake bus crossing and keeps a sticky overrun flag for requests
// that arrive while a transfer is still in progress.
module sync_bank #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int DATABITS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   async_in,
  input  logic [2*CHANNELS-1:0] mode_in,
  output logic [CHANNELS-1:0]   sync_out,
  input  logic                  req_toggle_in,
  input  logic [DATABITS-1:0]   data_in,
  output logic                  ack_toggle_out,
  output logic [DATABITS-1:0]   data_out,
  output logic                  valid_out,
  output logic                  overrun_out
);

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_ANY   = 2'b11;

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("sync_bank: CHANNELS=%0d outside 1..32", CHANNELS);
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_bank: STAGES=%0d outside 2..4", STAGES);
  end
  if (DATABITS < 1 || DATABITS > 64) begin : g_bad_databits
    $error("sync_bank: DATABITS=%0d outside 1..64", DATABITS);
  end

  // Selects the per-channel result from the synchronised level and its
  // one-cycle-delayed copy.
  function automatic logic edge_select(input logic [1:0] mode,
                                       input logic       last,
                                       input logic       prev);
    logic res;
    case (mode)
      MODE_LEVEL: res = last;
      MODE_RISE:  res = last & ~prev;
      MODE_FALL:  res = ~last & prev;
      MODE_ANY:   res = last ^ prev;
      default:    res = last;
    endcase
    return res;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  // Bit 0 of each chain is the first flop, which samples the async input.
  // Bit STAGES-1 is the synchronised level.
  logic [CHANNELS-1:0][STAGES-1:0] chan_sync_p0;
  logic [CHANNELS-1:0]             chan_prev_p1;
  logic [STAGES-1:0]               req_sync_p0;
  logic                            req_prev_p1;
  logic                            req_last;
  logic                            req_seen;
  state_t                          state;

  assign req_last = req_sync_p0[STAGES-1];
  assign req_seen = req_last ^ req_prev_p1;

  // Channel synchronisers, delayed copies and mode-selected output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chan_sync_p0 <= '0;
      chan_prev_p1 <= '0;
      sync_out     <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        chan_sync_p0[i] <= {chan_sync_p0[i][STAGES-2:0], async_in[i]};
        // The delayed copy is kept regardless of mode. A mode change
        // therefore only alters what is selected and never alters the
        // chain state.
        chan_prev_p1[i] <= chan_sync_p0[i][STAGES-1];
        sync_out[i]     <= edge_select(mode_in[2*i +: 2],
                                       chan_sync_p0[i][STAGES-1],
                                       chan_prev_p1[i]);
      end
    end
  end

  // Request toggle synchroniser and its edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync_p0 <= '0;
      req_prev_p1 <= 1'b0;
    end else begin
      req_sync_p0 <= {req_sync_p0[STAGES-2:0], req_toggle_in};
      req_prev_p1 <= req_last;
    end
  end

  // Handshake FSM: capture the bus, pulse valid, then return the ack toggle.
  // A request seen mid-transfer is dropped and latched as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      data_out       <= '0;
      valid_out      <= 1'b0;
      ack_toggle_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          if (req_seen) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The source holds data_in stable until it sees the ack, so the
          // bus is settled by the time the request has crossed.
          data_out  <= data_in;
          valid_out <= 1'b1;
          state     <= ACK;
          if (req_seen) begin
            overrun_out <= 1'b1;
          end
        end
        ACK: begin
          ack_toggle_out <= ~ack_toggle_out;
          valid_out      <= 1'b0;
          state          <= IDLE;
          if (req_seen) begin
            overrun_out <= 1'b1;
          end
        end
        default: begin
          valid_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_bank.sv
// Bench for sync_bank: the default configuration, plus a STAGES=4 /
// CHANNELS=1 / DATABITS=1 instance. Stimulus pushes the expected responses
// into queues, and a negedge monitor pops each entry and compares it.
module tb_sync_bank;

  localparam int L_SYNC = 0, L_VALID = 1, L_ACK = 2, L_OVR = 3, L_DATA = 4;
  localparam int L_SYNC4 = 5, L_VALID4 = 6, L_ACK4 = 7, L_DATA4 = 8;
  localparam int E_VALID = 10, E_ACK = 11, E_OVR = 12, E_VALID4 = 13, E_ACK4 = 14;

  typedef struct {
    int          cyc;
    int          id;
    logic [63:0] v;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  async_in;
  logic [7:0]  mode_in;
  logic [3:0]  sync_out;
  logic        req_toggle_in;
  logic [23:0] data_in;
  logic        ack_toggle_out;
  logic [23:0] data_out;
  logic        valid_out;
  logic        overrun_out;

  logic [0:0]  async4;
  logic [1:0]  mode4;
  logic [0:0]  sync4;
  logic        req4;
  logic [0:0]  data4;
  logic        ack4;
  logic [0:0]  dout4;
  logic        vld4;
  logic        ovr4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ent_t lvl_q[$];
  ent_t ev_q[$];
  logic ack_d = 1'b0;
  logic ack4_d = 1'b0;
  logic ovr_d = 1'b0;

  sync_bank dut (
    .clk(clk), .rst(rst), .async_in(async_in), .mode_in(mode_in),
    .sync_out(sync_out), .req_toggle_in(req_toggle_in), .data_in(data_in),
    .ack_toggle_out(ack_toggle_out), .data_out(data_out),
    .valid_out(valid_out), .overrun_out(overrun_out)
  );

  sync_bank #(.CHANNELS(1), .STAGES(4), .DATABITS(1)) dut4 (
    .clk(clk), .rst(rst), .async_in(async4), .mode_in(mode4),
    .sync_out(sync4), .req_toggle_in(req4), .data_in(data4),
    .ack_toggle_out(ack4), .data_out(dout4),
    .valid_out(vld4), .overrun_out(ovr4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string nm(input int id);
    case (id)
      L_SYNC:   return "sync_out";
      L_VALID:  return "valid_out";
      L_ACK:    return "ack_toggle_out";
      L_OVR:    return "overrun_out";
      L_DATA:   return "data_out";
      L_SYNC4:  return "s4.sync_out";
      L_VALID4: return "s4.valid_out";
      L_ACK4:   return "s4.ack_toggle_out";
      L_DATA4:  return "s4.data_out";
      E_VALID:  return "valid_pulse";
      E_ACK:    return "ack_toggle";
      E_OVR:    return "overrun_rise";
      E_VALID4: return "s4.valid_pulse";
      E_ACK4:   return "s4.ack_toggle";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [63:0] lvl_val(input int id);
    case (id)
      L_SYNC:   return 64'(sync_out);
      L_VALID:  return 64'(valid_out);
      L_ACK:    return 64'(ack_toggle_out);
      L_OVR:    return 64'(overrun_out);
      L_DATA:   return 64'(data_out);
      L_SYNC4:  return 64'(sync4);
      L_VALID4: return 64'(vld4);
      L_ACK4:   return 64'(ack4);
      L_DATA4:  return 64'(dout4);
      default:  return 64'hDEAD;
    endcase
  endfunction

  task automatic push_l(input int c, input int id, input logic [63:0] v);
    ent_t e;
    e.cyc = c; e.id = id; e.v = v;
    lvl_q.push_back(e);
  endtask

  task automatic push_e(input int c, input int id, input logic [63:0] v);
    ent_t e;
    e.cyc = c; e.id = id; e.v = v;
    ev_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Matches an observed output event against the expected event queue.
  task automatic take_ev(input int id, input logic [63:0] act);
    int hit;
    hit = -1;
    foreach (ev_q[k]) begin
      if (hit < 0 && ev_q[k].id == id && ev_q[k].cyc == cyc) hit = k;
    end
    if (hit < 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected at cyc=%0d got=%0h exp=none", nm(id), cyc, act);
    end else begin
      chk(nm(id), act, ev_q[hit].v);
      ev_q.delete(hit);
    end
  endtask

  // Monitor: compares the scheduled level checks and every output event.
  always @(negedge clk) begin
    for (int k = lvl_q.size() - 1; k >= 0; k--) begin
      if (lvl_q[k].cyc == cyc) begin
        chk(nm(lvl_q[k].id), lvl_val(lvl_q[k].id), lvl_q[k].v);
        lvl_q.delete(k);
      end
    end
    if (valid_out === 1'b1) take_ev(E_VALID, 64'(data_out));
    if (ack_toggle_out !== ack_d) take_ev(E_ACK, 64'(ack_toggle_out));
    if (overrun_out === 1'b1 && ovr_d !== 1'b1) take_ev(E_OVR, 64'd1);
    if (vld4 === 1'b1) take_ev(E_VALID4, 64'(dout4));
    if (ack4 !== ack4_d) take_ev(E_ACK4, 64'(ack4));
    ack_d  <= ack_toggle_out;
    ack4_d <= ack4;
    ovr_d  <= overrun_out;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; async_in = 4'hF; mode_in = 8'h00; req_toggle_in = 1'b0;
    data_in = 24'h0; async4 = 1'b0; mode4 = 2'b00; req4 = 1'b0; data4 = 1'b0;

    // Reset state after three reset edges.
    push_l(3, L_SYNC, 0);  push_l(3, L_VALID, 0); push_l(3, L_ACK, 0);
    push_l(3, L_OVR, 0);   push_l(3, L_DATA, 0);  push_l(3, L_SYNC4, 0);
    push_l(3, L_VALID4, 0); push_l(3, L_ACK4, 0); push_l(3, L_DATA4, 0);
    tick(3);
    rst = 1'b0;
    push_l(4, L_SYNC, 4'h0); push_l(5, L_SYNC, 4'h0); push_l(6, L_SYNC, 4'hF);
    tick(3);                                   // cyc 6
    async_in = 4'h0;
    push_l(7, L_SYNC, 4'hF); push_l(8, L_SYNC, 4'hF); push_l(9, L_SYNC, 4'h0);
    tick(4);                                   // cyc 10
    mode_in = 8'b11_10_01_00;
    for (int c = 11; c <= 14; c++) push_l(c, L_SYNC, 4'h0);
    tick(2);                                   // cyc 12
    async_in = 4'hF;
    push_l(15, L_SYNC, 4'b1011);
    for (int c = 16; c <= 19; c++) push_l(c, L_SYNC, 4'b0001);
    tick(5);                                   // cyc 17
    async_in = 4'h0;
    push_l(20, L_SYNC, 4'b1100); push_l(21, L_SYNC, 4'h0); push_l(22, L_SYNC, 4'h0);

    tick(7);                                   // cyc 24: single transfer
    data_in = 24'hA5C3F0; req_toggle_in = 1'b1;
    push_e(28, E_VALID, 24'hA5C3F0); push_e(29, E_ACK, 1);
    push_l(29, L_VALID, 0); push_l(30, L_DATA, 24'hA5C3F0);
    push_l(30, L_OVR, 0);   push_l(31, L_ACK, 1);

    tick(10);                                  // cyc 34: overrun
    data_in = 24'h123456; req_toggle_in = 1'b0;
    push_e(38, E_VALID, 24'h123456); push_e(39, E_ACK, 0);
    tick(2);                                   // cyc 36
    req_toggle_in = 1'b1;
    push_e(39, E_OVR, 1);
    tick(4);                                   // cyc 40
    data_in = 24'h654321;
    push_l(45, L_OVR, 1); push_l(45, L_DATA, 24'h123456);
    push_l(45, L_ACK, 0); push_l(49, L_OVR, 1);

    tick(10);                                  // cyc 50: reset clears overrun
    rst = 1'b1;
    push_l(52, L_OVR, 0); push_l(52, L_DATA, 0); push_l(52, L_ACK, 0);
    push_l(52, L_VALID, 0); push_l(52, L_SYNC, 0);
    tick(2);                                   // cyc 52
    rst = 1'b0;                                // request still 1 -> new request
    push_e(56, E_VALID, 24'h654321); push_e(57, E_ACK, 1); push_l(58, L_OVR, 0);

    tick(8);                                   // cyc 60: STAGES=4 instance
    async4 = 1'b1; req4 = 1'b1; data4 = 1'b1;
    push_l(64, L_SYNC4, 0); push_l(65, L_SYNC4, 1);
    push_e(66, E_VALID4, 1); push_e(67, E_ACK4, 1); push_l(67, L_VALID4, 0);

    tick(15);
    checks++;
    if (lvl_q.size() != 0 || ev_q.size() != 0) errors++;
    foreach (lvl_q[k])
      $display("FAIL %s missing check cyc=%0d exp=%0h", nm(lvl_q[k].id), lvl_q[k].cyc, lvl_q[k].v);
    foreach (ev_q[k])
      $display("FAIL %s missing event cyc=%0d exp=%0h", nm(ev_q[k].id), ev_q[k].cyc, ev_q[k].v);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
